// File: rtl/la_pdfd.sv
// la_pdfd: four-lane look-ahead PAM-5 decision-feedback decoder with a fixed 15-edge latency
module la_pdfd (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  io_rxSamples_0,
  input  logic [7:0]  io_rxSamples_1,
  input  logic [7:0]  io_rxSamples_2,
  input  logic [7:0]  io_rxSamples_3,
  input  logic [7:0]  io_taps_0,
  input  logic [7:0]  io_taps_1,
  input  logic [7:0]  io_taps_2,
  input  logic [7:0]  io_taps_3,
  input  logic [7:0]  io_taps_4,
  input  logic [7:0]  io_taps_5,
  input  logic [7:0]  io_taps_6,
  input  logic [7:0]  io_taps_7,
  input  logic [7:0]  io_taps_8,
  input  logic [7:0]  io_taps_9,
  input  logic [7:0]  io_taps_10,
  input  logic [7:0]  io_taps_11,
  input  logic [7:0]  io_taps_12,
  input  logic [7:0]  io_taps_13,
  output logic [11:0] io_rxData,
  output logic        io_rxValid
);
  logic [7:0]  smp [4];
  logic [7:0]  tap [14];
  logic [2:0]  hist_q [4][14];
  logic [11:0] dly_q [14];
  logic [3:0]  cnt_q;
  logic [15:0] part_d [4];
  logic [2:0]  cand_d [4][5];
  logic [2:0]  dec_d [4];
  logic [2:0]  sel_d;

  assign smp = '{io_rxSamples_0, io_rxSamples_1, io_rxSamples_2, io_rxSamples_3};
  assign tap = '{io_taps_0, io_taps_1, io_taps_2, io_taps_3, io_taps_4, io_taps_5, io_taps_6,
                 io_taps_7, io_taps_8, io_taps_9, io_taps_10, io_taps_11, io_taps_12, io_taps_13};

  function automatic logic [15:0] sx8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

  function automatic logic [15:0] sx3(input logic [2:0] v);
    return {{13{v[2]}}, v};
  endfunction

  function automatic logic [2:0] slice(input logic signed [15:0] c);
    return c <= -16'sd78 ? 3'b110 : c <= -16'sd27 ? 3'b111 : c <= 16'sd25 ? 3'b000 :
           c <= 16'sd75 ? 3'b001 : 3'b010;
  endfunction

  // ISI from taps 1..13, five candidate slices for the tap-0 term, previous decision picks one
  always_comb begin
    sel_d = '0;
    for (int l = 0; l < 4; l++) begin
      part_d[l] = '0;
      for (int k = 1; k < 14; k++) part_d[l] = part_d[l] + sx8(tap[k]) * sx3(hist_q[l][k]);
      for (int j = 0; j < 5; j++)
        cand_d[l][j] = slice(sx8(smp[l]) - part_d[l] - sx8(tap[0]) * 16'(j - 2));
      sel_d = hist_q[l][0] + 3'd2;
      dec_d[l] = cand_d[l][sel_d];
    end
  end

  // decision history, output delay line and output-valid counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int l = 0; l < 4; l++)
        for (int k = 0; k < 14; k++) hist_q[l][k] <= '0;
      for (int s = 0; s < 14; s++) dly_q[s] <= '0;
      cnt_q <= '0;
    end else begin
      for (int l = 0; l < 4; l++) begin
        hist_q[l][0] <= dec_d[l];
        for (int k = 1; k < 14; k++) hist_q[l][k] <= hist_q[l][k-1];
      end
      dly_q[0] <= {hist_q[3][0], hist_q[2][0], hist_q[1][0], hist_q[0][0]};
      for (int s = 1; s < 14; s++) dly_q[s] <= dly_q[s-1];
      cnt_q <= cnt_q == 4'd15 ? cnt_q : cnt_q + 4'd1;
    end
  end

  assign io_rxData  = dly_q[13];
  assign io_rxValid = cnt_q == 4'd15;
endmodule

// File: tb/tb_la_pdfd.sv
// tb_la_pdfd: randomized scoreboard bench for the look-ahead PAM-5 decision-feedback decoder
module tb_la_pdfd;
  logic        clock = 0, reset = 1;
  logic [7:0]  smp [4];
  logic [7:0]  tap [14];
  logic [11:0] io_rxData;
  logic        io_rxValid;
  int          tp [14];
  int          hist [4][14];
  int          lv [5] = '{-103, -52, 0, 51, 101};
  logic [11:0] sb [$];
  int          n_chk = 0, n_fail = 0, cnt = 0;
  bit          want_first = 1, draining = 0;

  la_pdfd dut (
    .clock(clock), .reset(reset),
    .io_rxSamples_0(smp[0]), .io_rxSamples_1(smp[1]), .io_rxSamples_2(smp[2]), .io_rxSamples_3(smp[3]),
    .io_taps_0(tap[0]), .io_taps_1(tap[1]), .io_taps_2(tap[2]), .io_taps_3(tap[3]),
    .io_taps_4(tap[4]), .io_taps_5(tap[5]), .io_taps_6(tap[6]), .io_taps_7(tap[7]),
    .io_taps_8(tap[8]), .io_taps_9(tap[9]), .io_taps_10(tap[10]), .io_taps_11(tap[11]),
    .io_taps_12(tap[12]), .io_taps_13(tap[13]),
    .io_rxData(io_rxData), .io_rxValid(io_rxValid)
  );

  always #5 clock = ~clock;

  function automatic int slicer(input int c);
    return c <= -78 ? -2 : c <= -27 ? -1 : c <= 25 ? 0 : c <= 75 ? 1 : 2;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // called at a falling edge: drive one sample per lane, predict the decision, return at next falling edge
  task automatic step(input int a, input int b, input int c, input int d);
    int v [4];
    int isi, dec;
    logic [11:0] w;
    v = '{a, b, c, d};
    w = '0;
    for (int k = 0; k < 14; k++) tap[k] = 8'(tp[k]);
    for (int l = 0; l < 4; l++) begin
      smp[l] = 8'(v[l]);
      isi = 0;
      for (int k = 0; k < 14; k++) isi += tp[k] * hist[l][k];
      dec = slicer(v[l] - isi);
      for (int k = 13; k > 0; k--) hist[l][k] = hist[l][k-1];
      hist[l][0] = dec;
      w[3*l +: 3] = 3'(dec);
    end
    sb.push_back(w);
    @(negedge clock);
  endtask

  task automatic clear_model();
    for (int l = 0; l < 4; l++)
      for (int k = 0; k < 14; k++) hist[l][k] = 0;
    sb.delete();
  endtask

  function automatic int rl();
    return lv[$urandom_range(4)];
  endfunction

  always @(posedge clock) begin
    logic [11:0] e;
    #1;
    if (reset) cnt = 0;
    else if (cnt < 15) cnt++;
    chk("valid", 16'(io_rxValid), 16'(cnt >= 15));
    if (io_rxValid && !reset) begin
      if (sb.size() == 0) begin
        if (!draining) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_underflow: got data %h expected none at %0t", io_rxData, $time);
        end
      end else begin
        e = sb.pop_front();
        chk("data", 16'(io_rxData), 16'(e));
        if (want_first) begin
          chk("first_word", 16'(io_rxData), 16'h023E);
          want_first = 0;
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < 14; k++) begin tp[k] = 0; tap[k] = '0; end
    for (int l = 0; l < 4; l++) smp[l] = '0;
    clear_model();
    #2;
    chk("reset_data", 16'(io_rxData), 16'h0);
    chk("reset_valid", 16'(io_rxValid), 16'h0);
    repeat (2) @(negedge clock);
    reset = 0;
    step(-103, -52, 0, 51);
    repeat (100) step(rl(), rl(), rl(), rl());
    step(-78, -77, -27, -26);
    step(25, 26, 75, 76);
    step(-128, 127, -103, 101);
    tp[0] = 20;
    step(101, rl(), rl(), rl());
    step(40, rl(), rl(), rl());
    tp[0] = 0;
    repeat (14) step(0, 0, 0, 0);
    tp[13] = 10;
    step(0, 0, 101, 0);
    repeat (13) step(0, 0, 0, 0);
    step(0, 0, 20, 0);
    step(0, 0, 0, 0);
    for (int k = 0; k < 14; k++) tp[k] = int'($urandom_range(40)) - 20;
    repeat (60) step(int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128,
                     int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128);
    @(posedge clock);
    #2 reset = 1;
    #1;
    chk("async_rst_data", 16'(io_rxData), 16'h0);
    chk("async_rst_valid", 16'(io_rxValid), 16'h0);
    clear_model();
    repeat (2) @(negedge clock);
    reset = 0;
    step(101, -103, 51, -52);
    repeat (80) step(int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128,
                     int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128);
    draining = 1;
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clock);
    chk("drain_empty", 16'(sb.size()), 16'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
